// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if: dispatch, common-data-bus and issue signals for the ALU issue queue
interface alu_issue_queue_if;
    logic        dis_valid;
    logic        dis_ready;
    logic [3:0]  dis_opcode;
    logic [4:0]  dis_shfamt;
    logic [4:0]  dis_tag;
    logic [31:0] dis_op1;
    logic [31:0] dis_op2;
    logic        dis_op1_valid;
    logic        dis_op2_valid;
    logic [4:0]  dis_op1_tag;
    logic [4:0]  dis_op2_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [31:0] iss_operand1;
    logic [31:0] iss_operand2;
    logic [3:0]  iss_opcode;
    logic [4:0]  iss_shfamt;
    logic [4:0]  iss_tag;
    logic [3:0]  iq_count;

    modport master (
        output dis_valid, dis_opcode, dis_shfamt, dis_tag, dis_op1, dis_op2,
               dis_op1_valid, dis_op2_valid, dis_op1_tag, dis_op2_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  dis_ready, iss_valid, iss_operand1, iss_operand2, iss_opcode,
               iss_shfamt, iss_tag, iq_count
    );

    modport slave (
        input  dis_valid, dis_opcode, dis_shfamt, dis_tag, dis_op1, dis_op2,
               dis_op1_valid, dis_op2_valid, dis_op1_tag, dis_op2_tag,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output dis_ready, iss_valid, iss_operand1, iss_operand2, iss_opcode,
               iss_shfamt, iss_tag, iq_count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: age-ordered ALU reservation queue with CDB wakeup and oldest-ready issue
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_issue_queue_if.slave   io
);
    typedef struct packed {
        logic        v;
        logic [3:0]  opc;
        logic [4:0]  shf;
        logic [4:0]  tag;
        logic [31:0] a;
        logic        ra;
        logic [4:0]  ta;
        logic [31:0] b;
        logic        rb;
        logic [4:0]  tb;
    } ent_t;

    ent_t       ent_q [DEPTH];
    ent_t       ent_d [DEPTH];
    ent_t       w     [DEPTH+1];
    ent_t       nw;
    ent_t       iss_e;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] sel;
    logic [3:0] pos;
    logic       issue;
    logic       disp;

    function automatic ent_t wake(ent_t e, logic cv, logic [4:0] ct, logic [31:0] cd);
        ent_t r;
        r = e;
        if (cv && e.v && !e.ra && e.ta == ct) begin
            r.a  = cd;
            r.ra = 1'b1;
        end
        if (cv && e.v && !e.rb && e.tb == ct) begin
            r.b  = cd;
            r.rb = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        iss_e = '0;
        sel   = '0;
        // scan youngest to oldest so the last hit is the oldest eligible entry
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].v && ent_q[i].ra && ent_q[i].rb) begin
                iss_e = ent_q[i];
                sel   = 4'(i);
            end
        end
        issue  = iss_e.v && io.iss_ready && !flush;
        disp   = io.dis_valid && io.dis_ready && !flush;
        pos    = cnt_q - 4'(issue);
        nw     = '0;
        nw.v   = 1'b1;
        nw.opc = io.dis_opcode;
        nw.shf = io.dis_shfamt;
        nw.tag = io.dis_tag;
        nw.a   = io.dis_op1;
        nw.ra  = io.dis_op1_valid;
        nw.ta  = io.dis_op1_tag;
        nw.b   = io.dis_op2;
        nw.rb  = io.dis_op2_valid;
        nw.tb  = io.dis_op2_tag;
        nw     = wake(nw, io.cdb_valid, io.cdb_tag, io.cdb_data);
        w[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) w[i] = wake(ent_q[i], io.cdb_valid, io.cdb_tag, io.cdb_data);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (issue && 4'(i) >= sel) ? w[i+1] : w[i];
            if (disp && 4'(i) == pos) ent_d[i] = nw;
            if (flush) ent_d[i].v = 1'b0;
        end
        cnt_d = flush ? '0 : cnt_q + 4'(disp) - 4'(issue);
    end

    assign io.dis_ready    = cnt_q < 4'(DEPTH);
    assign io.iss_valid    = iss_e.v;
    assign io.iss_operand1 = iss_e.a;
    assign io.iss_operand2 = iss_e.b;
    assign io.iss_opcode   = iss_e.opc;
    assign io.iss_shfamt   = iss_e.shf;
    assign io.iss_tag      = iss_e.tag;
    assign io.iq_count     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed stimulus with an expected-issue scoreboard checked by a forked monitor
module tb_alu_issue_queue;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  opc;
        logic [4:0]  shf;
    } exp_t;

    exp_t sb[$];

    alu_issue_queue_if io();

    alu_issue_queue #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .io(io));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #2;
    endtask

    task automatic clr();
        io.dis_valid = 0; io.dis_opcode = 0; io.dis_shfamt = 0; io.dis_tag = 0;
        io.dis_op1 = 0; io.dis_op2 = 0; io.dis_op1_valid = 0; io.dis_op2_valid = 0;
        io.dis_op1_tag = 0; io.dis_op2_tag = 0;
        io.cdb_valid = 0; io.cdb_tag = 0; io.cdb_data = 0;
    endtask

    task automatic disp(input logic [4:0] tag, input logic [3:0] opc, input logic [4:0] shf,
                        input logic [31:0] a, input logic va, input logic [4:0] ta,
                        input logic [31:0] b, input logic vb, input logic [4:0] tb);
        io.dis_valid = 1; io.dis_tag = tag; io.dis_opcode = opc; io.dis_shfamt = shf;
        io.dis_op1 = a; io.dis_op1_valid = va; io.dis_op1_tag = ta;
        io.dis_op2 = b; io.dis_op2_valid = vb; io.dis_op2_tag = tb;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] d);
        io.cdb_valid = 1; io.cdb_tag = t; io.cdb_data = d;
    endtask

    task automatic push(input logic [4:0] tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] opc, input logic [4:0] shf);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.opc = opc; e.shf = shf;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 0; flush = 0; io.iss_ready = 0;
        clr();
        fork
            forever begin
                @(negedge clk);
                if (rst_n && io.iss_valid && io.iss_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_issue_tag", {27'd0, io.iss_tag}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("iss_tag", {27'd0, io.iss_tag}, {27'd0, e.tag});
                        chk("iss_operand1", io.iss_operand1, e.a);
                        chk("iss_operand2", io.iss_operand2, e.b);
                        chk("iss_opcode", {28'd0, io.iss_opcode}, {28'd0, e.opc});
                        chk("iss_shfamt", {27'd0, io.iss_shfamt}, {27'd0, e.shf});
                    end
                end
            end
        join_none

        #3;
        chk("rst_count", {28'd0, io.iq_count}, 0);
        chk("rst_iss_valid", {31'd0, io.iss_valid}, 0);
        chk("rst_iss_tag", {27'd0, io.iss_tag}, 0);
        chk("rst_iss_op1", io.iss_operand1, 0);
        chk("rst_dis_ready", {31'd0, io.dis_ready}, 1);
        tick();
        rst_n = 1;
        tick();

        // basic ready dispatch, one-cycle issue latency
        io.iss_ready = 1;
        disp(5'd3, 4'h0, 5'd0, 32'd5, 1, 5'd0, 32'd7, 1, 5'd0);
        push(5'd3, 32'd5, 32'd7, 4'h0, 5'd0);
        tick(); clr(); probe();
        chk("t1_iss_valid", {31'd0, io.iss_valid}, 1);
        chk("t1_count", {28'd0, io.iq_count}, 1);
        tick(); probe();
        chk("t1_count_after", {28'd0, io.iq_count}, 0);

        // operand 2 waits on tag 9, woken by a later broadcast
        disp(5'd4, 4'h2, 5'd3, 32'd1, 1, 5'd0, 32'd0, 0, 5'd9);
        tick(); clr(); probe();
        chk("t2_wait_valid", {31'd0, io.iss_valid}, 0);
        tick();
        cdb(5'd9, 32'h10);
        push(5'd4, 32'd1, 32'h10, 4'h2, 5'd3);
        probe();
        chk("t2_cdb_not_same_cycle", {31'd0, io.iss_valid}, 0);
        tick(); clr(); probe();
        chk("t2_woken_valid", {31'd0, io.iss_valid}, 1);
        tick(); probe();
        chk("t2_count", {28'd0, io.iq_count}, 0);

        // capture at dispatch from a same-cycle broadcast
        disp(5'd5, 4'h5, 5'd31, 32'h1234, 0, 5'd2, 32'd3, 1, 5'd0);
        cdb(5'd2, 32'hAA);
        push(5'd5, 32'hAA, 32'd3, 4'h5, 5'd31);
        tick(); clr(); probe();
        chk("t3_valid", {31'd0, io.iss_valid}, 1);
        tick(); probe();
        chk("t3_count", {28'd0, io.iq_count}, 0);

        // fill, overflow dropped, then drain in age order
        io.iss_ready = 0;
        for (int i = 0; i < 4; i++) begin
            disp(5'(10 + i), 4'(i), 5'(i), 32'(i), 1, 5'd0, 32'(100 + i), 1, 5'd0);
            push(5'(10 + i), 32'(i), 32'(100 + i), 4'(i), 5'(i));
            tick();
        end
        clr(); probe();
        chk("t4_full_ready", {31'd0, io.dis_ready}, 0);
        chk("t4_full_count", {28'd0, io.iq_count}, 4);
        tick();
        disp(5'd14, 4'hF, 5'd0, 32'd9, 1, 5'd0, 32'd9, 1, 5'd0);
        tick(); clr(); probe();
        chk("t4_drop_count", {28'd0, io.iq_count}, 4);
        chk("t4_stable_tag", {27'd0, io.iss_tag}, 10);
        io.iss_ready = 1;
        tick();
        io.iss_ready = 0;
        probe();
        chk("t4_count3", {28'd0, io.iq_count}, 3);
        chk("t4_ready_again", {31'd0, io.dis_ready}, 1);
        io.iss_ready = 1;
        tick(); tick(); tick(); probe();
        chk("t4_drained", {28'd0, io.iq_count}, 0);

        // younger ready entry bypasses blocked older one; then dispatch+issue+wakeup together
        io.iss_ready = 0;
        disp(5'd20, 4'h1, 5'd1, 32'd0, 0, 5'd7, 32'd2, 1, 5'd0);
        tick();
        disp(5'd21, 4'h3, 5'd4, 32'd6, 1, 5'd0, 32'd8, 1, 5'd0);
        tick(); clr(); probe();
        push(5'd21, 32'd6, 32'd8, 4'h3, 5'd4);
        push(5'd20, 32'h77, 32'd2, 4'h1, 5'd1);
        push(5'd22, 32'd8, 32'd9, 4'h6, 5'd2);
        chk("t5_younger_first", {27'd0, io.iss_tag}, 21);
        io.iss_ready = 1;
        disp(5'd22, 4'h6, 5'd2, 32'd8, 1, 5'd0, 32'd9, 1, 5'd0);
        cdb(5'd7, 32'h77);
        tick(); clr(); probe();
        chk("t5_count_same", {28'd0, io.iq_count}, 2);
        chk("t5_older_next", {27'd0, io.iss_tag}, 20);
        tick(); probe();
        chk("t5_count1", {28'd0, io.iq_count}, 1);
        chk("t5_last_tag", {27'd0, io.iss_tag}, 22);
        tick(); probe();
        chk("t5_empty", {28'd0, io.iq_count}, 0);

        // flush overrides a same-cycle dispatch
        io.iss_ready = 0;
        for (int i = 0; i < 3; i++) begin
            disp(5'(1 + i), 4'h0, 5'd0, 32'd1, 1, 5'd0, 32'd1, 1, 5'd0);
            tick();
        end
        clr(); probe();
        chk("t6_count3", {28'd0, io.iq_count}, 3);
        tick();
        flush = 1;
        disp(5'd30, 4'h0, 5'd0, 32'd1, 1, 5'd0, 32'd1, 1, 5'd0);
        tick();
        flush = 0;
        clr(); probe();
        chk("t6_flush_count", {28'd0, io.iq_count}, 0);
        chk("t6_flush_valid", {31'd0, io.iss_valid}, 0);
        chk("t6_flush_ready", {31'd0, io.dis_ready}, 1);

        // asynchronous reset mid-fill discards everything
        for (int i = 0; i < 2; i++) begin
            disp(5'(24 + i), 4'h0, 5'd0, 32'd1, 1, 5'd0, 32'd1, 1, 5'd0);
            tick();
        end
        clr();
        rst_n = 0;
        #1;
        chk("t7_rst_count", {28'd0, io.iq_count}, 0);
        chk("t7_rst_valid", {31'd0, io.iss_valid}, 0);
        tick();
        rst_n = 1;
        io.iss_ready = 1;
        tick(); tick(); tick(); probe();
        chk("t7_no_issue", {31'd0, io.iss_valid}, 0);
        chk("t7_count", {28'd0, io.iq_count}, 0);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (2..8).
REQ-002 Clk  in  1  sole clock, all state on rising edge.
REQ-003 Resetb  in  1  reset, asynchronous and active-low.
REQ-004 Flush  in  1  synchronous clear of all entries.
REQ-005 Dis_Valid  in  1  dispatch request.
REQ-006 Dis_Ready  out  1  queue can accept a dispatch this cycle.
REQ-007 Dis_Opcode  in  4  ALU opcode (ALU opcode encoding, passed unmodified).
REQ-008 Dis_Shfamt  in  5  shift amount.
REQ-009 Dis_Tag  in  5  destination tag.
REQ-010 Dis_Op1 / Dis_Op2  in  32 each  operand value.
REQ-011 Dis_Op1_Valid / Dis_Op2_Valid  in  1 each  operand value present.
REQ-012 Dis_Op1_Tag / Dis_Op2_Tag  in  5 each  producer tag when operand not present.
REQ-013 Cdb_Valid  in  1  common-data-bus broadcast valid.
REQ-014 Cdb_Tag  in  5  broadcast producer tag.
REQ-015 Cdb_Data  in  32  broadcast result value.
REQ-016 Iss_Valid  out  1  issue entry presented to ALU.
REQ-017 Iss_Ready  in  1  ALU accepts issue.
REQ-018 Iss_Operand1 / Iss_Operand2  out  32 each  operands to ALU.
REQ-019 Iss_Opcode  out  4, Iss_Shfamt  out  5, Iss_Tag  out  5  fields of issued entry.
REQ-020 Iq_Count  out  4  number of valid entries.

Function
REQ-021 Each entry SHALL hold valid, opcode, shfamt, tag, and per operand {value, ready, producer tag}.
REQ-022 Entries SHALL be kept in age order (index 0 oldest); removal SHALL compact younger entries down by one in the same edge.
REQ-023 Dis_Ready SHALL equal (Iq_Count < DEPTH) from registered state only; no same-cycle credit from a simultaneous issue.
REQ-024 Dispatch occurs when Dis_Valid && Dis_Ready; the new entry SHALL be written at the first free position after any compaction that edge.
REQ-025 At dispatch, a not-ready operand whose tag equals Cdb_Tag with Cdb_Valid=1 SHALL be captured ready with Cdb_Data.
REQ-026 Every valid not-ready operand whose producer tag equals Cdb_Tag with Cdb_Valid=1 SHALL become ready with Cdb_Data at that edge.
REQ-027 An entry is eligible when valid and both operands ready (registered); a CDB wakeup SHALL make it eligible no earlier than the next cycle.
REQ-028 Iss_Valid SHALL be high iff any entry is eligible; Iss_* fields SHALL show the oldest eligible entry, else all zero.
REQ-029 Issue occurs when Iss_Valid && Iss_Ready; that entry SHALL be removed at the edge; Iss_* SHALL stay stable while Iss_Valid && !Iss_Ready.
REQ-030 Minimum latency: dispatch with both operands ready at edge N -> Iss_Valid at cycle after N.
REQ-031 Simultaneous dispatch, issue and CDB wakeup in one cycle SHALL all take effect; Iq_Count SHALL change by (+dispatch -issue).
REQ-032 Flush=1 SHALL clear all valid bits at the edge and override dispatch and issue that cycle.
REQ-033 Dispatch while full SHALL be ignored; issue while empty SHALL not occur (Iss_Valid=0).
REQ-034 Queue is a pure scheduler: no arithmetic on operands; Iss_Tag SHALL equal dispatched Dis_Tag.

Reset
REQ-035 Resetb low SHALL immediately clear all entries; Iq_Count=0, Iss_Valid=0, Iss_* =0, Dis_Ready=1.
REQ-036 Reset asserted mid-operation SHALL discard all entries; no issue after release until new dispatch.

Verification
REQ-037 Dispatch ADD tag 3, Op1=5, Op2=7 both valid, Iss_Ready=1 -> next cycle Iss_Valid=1, Iss_Operand1=5, Iss_Operand2=7, Iss_Tag=3; following cycle Iq_Count=0.
REQ-038 Dispatch tag 4 with Op2 waiting on tag 9; Cdb_Valid=1, Cdb_Tag=9, Cdb_Data=0x10 two cycles later -> Iss_Valid=1 the cycle after, Iss_Operand2=0x10.
REQ-039 Same-cycle dispatch with Op1 waiting on tag 2 and CDB tag 2 data 0xAA -> entry eligible next cycle, Iss_Operand1=0xAA.
REQ-040 Fill DEPTH=4 entries with Iss_Ready=0 -> Dis_Ready=0, Iq_Count=4; fifth Dis_Valid dropped; Iss_Ready=1 one cycle -> Iq_Count=3, Dis_Ready=1.
REQ-041 Older entry blocked on tag, younger ready -> younger issues first; after wakeup older issues; order check by Iss_Tag.
REQ-042 Three entries queued, Flush=1 with Dis_Valid=1 -> next cycle Iq_Count=0, Iss_Valid=0; Resetb pulse mid-fill -> same.
